dbf_beam_sum: RTL and testbench
===============================

# dbf_beam_sum

Downstream combiner for the digital beamformer: takes the weighted complex products of NCH parallel dbf channel cells and sums them into one beam sample. It uses a pipelined adder tree, then runtime-selectable scaling with round-half-up, then saturation to the beam output width. It sits between the per-channel weighting cells and the beam-domain processing (pulse compression / FFT), and reports overflow and channel-valid misalignment through sticky flags.

## Interface
- NCH, 8, number of channels; power of 2, range 2..64
- IN_W, 33, per-channel I/Q input width, two's complement
- OUT_W, 16, beam output width, two's complement
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_inI  in  NCH*IN_W  channel I samples, channel k at bits [k*IN_W +: IN_W]
- data_inQ  in  NCH*IN_W  channel Q samples, same packing
- data_in_valid  in  NCH  per-channel valid, bit k for channel k
- shift_sel  in  5  right-shift amount applied after summation, 0..(SUM_W-1)
- clear_flags  in  1  single-cycle pulse, clears both sticky flags
- beam_outI  out  OUT_W  beam I sample
- beam_outQ  out  OUT_W  beam Q sample
- beam_out_valid  out  1  beam sample valid, one cycle per sample
- ovf_flag  out  1  sticky: at least one output sample exceeded OUT_W range
- vld_err_flag  out  1  sticky: data_in_valid was neither all-zero nor all-one in some cycle

## Operation
- LOG = log2(NCH); SUM_W = IN_W + LOG (36 at defaults). All sums use sign extension to SUM_W; the tree cannot overflow.
- Stage 0 (input register): captures all channels, shift_sel and accept = &data_in_valid. shift_sel travels with the sample, so a mid-stream change takes effect exactly on the sample presented with it.
- Misalignment: if data_in_valid is neither all-zero nor all-one, the sample is dropped (accept=0) and vld_err_flag sets.
- Stages 1..LOG: binary adder tree, one register level per tree level; valid and shift ride alongside.
- Round stage: r = sum + (s>0 ? 2^(s-1) : 0) computed in SUM_W+1 bits, then arithmetic shift right by s (round half toward +inf).
- Output stage: if r is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], ovf_flag sets and the output follows Configuration; otherwise it is r[OUT_W-1:0].
- I and Q paths are identical and independent. ovf_flag sets if either path overflows.
- Sticky flags: set on event, cleared only by clear_flags or rst. If clear_flags and a set event occur in the same cycle, set wins.
- Data registers update only on valid beats, so outputs hold their last value while beam_out_valid=0.

## Timing
- Latency: LOG+3 cycles from the input edge to beam_out_valid (6 at NCH=8). Throughput is one sample per clock with no stall and no backpressure.
- Every valid-in cycle yields exactly one valid-out cycle LOG+3 later. Order is preserved.
- Reset values: beam_outI=0, beam_outQ=0, beam_out_valid=0, ovf_flag=0, vld_err_flag=0. All pipeline valid bits clear.
- Reset mid-operation: in-flight samples are discarded. No valid output appears until LOG+3 cycles after the first post-reset accepted input.
- shift_sel values ≥ SUM_W are clamped to SUM_W-1.

## Configuration
- DBF_BEAM_SUM_SAT_EN defined: out-of-range results saturate to +2^(OUT_W-1)-1 or -2^(OUT_W-1).
- DBF_BEAM_SUM_SAT_EN undefined: out-of-range results wrap (low OUT_W bits of r).
- ovf_flag behaves identically in both builds.

## Test plan
- NCH=8; all channels I=1000, Q=-1000, all valid, shift_sel=0 -> 6 cycles later beam_outI=8000, beam_outQ=-8000, valid for one cycle.
- Only channel 0 I=3, second sample I=-3, shift_sel=1 -> outputs 2 then -1 (half rounds up), ovf_flag stays 0.
- All channels I=2^20, shift_sel=0 -> with macro beam_outI=32767 and ovf_flag=1; without macro beam_outI=0 and ovf_flag=1. A clear_flags pulse returns ovf_flag to 0.
- data_in_valid=8'b0111_1111 for one cycle -> no beam_out_valid for that sample, vld_err_flag=1 held until clear_flags.
- 100-sample continuous stream with channel k I=k+n, shift_sel switched 0->2 at n=50 -> 100 consecutive valid outputs. Sample n=49 equals 28+8·49 unshifted; sample n=50 equals round((28+400)/4)=107.
- rst asserted for 1 cycle with 3 samples in flight -> next cycle all outputs and flags 0, none of the 3 samples emerge afterwards.

Source files
------------

// File: rtl/dbf_beam_sum.sv
// Beam combiner: pipelined adder tree over NCH channel products, round-half-up shift, range check.
// Optional build macro DBF_BEAM_SUM_SAT_EN: saturate out-of-range samples (default build wraps).
module dbf_beam_sum #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned IN_W  = 33,
  parameter int unsigned OUT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*IN_W-1:0]   data_inI,
  input  logic [NCH*IN_W-1:0]   data_inQ,
  input  logic [NCH-1:0]        data_in_valid,
  input  logic [4:0]            shift_sel,
  input  logic                  clear_flags,
  output logic [OUT_W-1:0]      beam_outI,
  output logic [OUT_W-1:0]      beam_outQ,
  output logic                  beam_out_valid,
  output logic                  ovf_flag,
  output logic                  vld_err_flag
);

  localparam int unsigned LOG    = $clog2(NCH);
  localparam int unsigned SUM_W  = IN_W + LOG;
  localparam int unsigned RW     = SUM_W + 1;
  localparam int unsigned NODES  = 2 * NCH - 1;
  localparam int unsigned SH_LIM = (SUM_W - 1 > 31) ? 31 : SUM_W - 1;
  localparam logic [4:0]  SH_MAX = 5'(SH_LIM);

  // Heap-ordered tree: node 0 is the root, leaves live at NCH-1 .. 2*NCH-2
  logic signed [SUM_W-1:0] node_i [NODES];
  logic signed [SUM_W-1:0] node_q [NODES];
  logic                    vld    [LOG+1];
  logic [4:0]              sh     [LOG+1];

  logic                    rnd_vld;
  logic signed [RW-1:0]    rnd_i;
  logic signed [RW-1:0]    rnd_q;

  logic                    accept_c;
  logic                    misalign_c;
  logic [4:0]              sh_in_c;
  logic signed [RW-1:0]    rnd_i_c;
  logic signed [RW-1:0]    rnd_q_c;
  logic                    ovf_i_c;
  logic                    ovf_q_c;
  logic [OUT_W-1:0]        out_i_c;
  logic [OUT_W-1:0]        out_q_c;

  function automatic logic signed [RW-1:0] round_shift(input logic signed [SUM_W-1:0] v,
                                                        input logic [4:0] s);
    logic signed [RW-1:0] t;
    t = RW'(v);
    if (s != 5'd0) t = t + (RW'(1) << (s - 5'd1));
    return t >>> s;
  endfunction

  function automatic logic out_of_range(input logic signed [RW-1:0] r);
    logic [RW-OUT_W:0] top;
    top = r[RW-1:OUT_W-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic [OUT_W-1:0] fit(input logic signed [RW-1:0] r);
`ifdef DBF_BEAM_SUM_SAT_EN
    logic [OUT_W-1:0] res;
    if (out_of_range(r))
      res = r[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      res = r[OUT_W-1:0];
    return res;
`else
    return r[OUT_W-1:0];
`endif
  endfunction

  always_comb begin
    accept_c   = &data_in_valid;
    misalign_c = (|data_in_valid) && !accept_c;
    sh_in_c    = (32'(shift_sel) > SH_LIM) ? SH_MAX : shift_sel;
    rnd_i_c    = round_shift(node_i[0], sh[LOG]);
    rnd_q_c    = round_shift(node_q[0], sh[LOG]);
    ovf_i_c    = out_of_range(rnd_i);
    ovf_q_c    = out_of_range(rnd_q);
    out_i_c    = fit(rnd_i);
    out_q_c    = fit(rnd_q);
  end

  // Input capture and adder tree; shift amount and valid travel with the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned n = 0; n < NODES; n++) begin
        node_i[n] <= '0;
        node_q[n] <= '0;
      end
      for (int unsigned l = 0; l <= LOG; l++) begin
        vld[l] <= 1'b0;
        sh[l]  <= '0;
      end
    end else begin
      vld[0] <= accept_c;
      if (accept_c) begin
        sh[0] <= sh_in_c;
        for (int unsigned k = 0; k < NCH; k++) begin
          node_i[NCH-1+k] <= SUM_W'($signed(data_inI[k*IN_W +: IN_W]));
          node_q[NCH-1+k] <= SUM_W'($signed(data_inQ[k*IN_W +: IN_W]));
        end
      end
      for (int unsigned l = 1; l <= LOG; l++) begin
        vld[l] <= vld[l-1];
        if (vld[l-1]) sh[l] <= sh[l-1];
      end
      for (int unsigned d = 0; d < LOG; d++) begin
        if (vld[LOG-d-1]) begin
          for (int unsigned i = (32'd1 << d) - 32'd1; i < (32'd2 << d) - 32'd1; i++) begin
            node_i[i] <= node_i[2*i+1] + node_i[2*i+2];
            node_q[i] <= node_q[2*i+1] + node_q[2*i+2];
          end
        end
      end
    end
  end

  // Round stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_vld <= 1'b0;
      rnd_i   <= '0;
      rnd_q   <= '0;
    end else begin
      rnd_vld <= vld[LOG];
      if (vld[LOG]) begin
        rnd_i <= rnd_i_c;
        rnd_q <= rnd_q_c;
      end
    end
  end

  // Output stage and sticky flags; a set event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      beam_outI      <= '0;
      beam_outQ      <= '0;
      beam_out_valid <= 1'b0;
      ovf_flag       <= 1'b0;
      vld_err_flag   <= 1'b0;
    end else begin
      beam_out_valid <= rnd_vld;
      if (rnd_vld) begin
        beam_outI <= out_i_c;
        beam_outQ <= out_q_c;
      end
      if (rnd_vld && (ovf_i_c || ovf_q_c)) ovf_flag <= 1'b1;
      else if (clear_flags)                ovf_flag <= 1'b0;
      if (misalign_c)       vld_err_flag <= 1'b1;
      else if (clear_flags) vld_err_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dbf_beam_sum.sv
// Randomized bench for dbf_beam_sum against a cycle-scheduled arithmetic reference model.
module tb_dbf_beam_sum;

  localparam int NCH   = 8;
  localparam int IN_W  = 33;
  localparam int OUT_W = 16;
  localparam int SUM_W = 36;
  localparam int LAT   = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH*IN_W-1:0] data_inI;
  logic [NCH*IN_W-1:0] data_inQ;
  logic [NCH-1:0]      data_in_valid;
  logic [4:0]          shift_sel;
  logic                clear_flags;
  logic [OUT_W-1:0]    beam_outI;
  logic [OUT_W-1:0]    beam_outQ;
  logic                beam_out_valid;
  logic                ovf_flag;
  logic                vld_err_flag;

  dbf_beam_sum #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .data_inI(data_inI), .data_inQ(data_inQ), .data_in_valid(data_in_valid),
    .shift_sel(shift_sel), .clear_flags(clear_flags),
    .beam_outI(beam_outI), .beam_outQ(beam_outQ), .beam_out_valid(beam_out_valid),
    .ovf_flag(ovf_flag), .vld_err_flag(vld_err_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  longint       ch_i [NCH];
  longint       ch_q [NCH];
  bit [NCH-1:0] vmask;
  int           sh;
  bit           clr;
  bit           rst_b;

  longint sched_i [int];
  longint sched_q [int];
  bit     sched_o [int];
  longint exp_i, exp_q;
  bit     exp_v, exp_ovf, exp_verr;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic longint rnd(input longint v, input int s);
    if (s == 0) return v;
    return (v + (longint'(1) <<< (s - 1))) >>> s;
  endfunction

  function automatic longint fit(input longint r, inout bit ov);
    logic [63:0]       rb;
    logic signed [15:0] w;
    if (r > 32767 || r < -32768) begin
      ov = 1'b1;
`ifdef DBF_BEAM_SUM_SAT_EN
      return (r > 0) ? 64'sd32767 : -64'sd32768;
`else
      rb = r;
      w  = rb[15:0];
      return longint'(w);
`endif
    end
    return r;
  endfunction

  task automatic apply();
    for (int k = 0; k < NCH; k++) begin
      data_inI[k*IN_W +: IN_W] = IN_W'(ch_i[k]);
      data_inQ[k*IN_W +: IN_W] = IN_W'(ch_q[k]);
    end
    data_in_valid = vmask;
    shift_sel     = 5'(sh);
    clear_flags   = clr;
    rst           = rst_b;
  endtask

  // One clock: advance the reference model at the edge, then compare every output
  task automatic tick();
    longint si, sq, oi, oq;
    int     s;
    bit     ov;
    @(posedge clk);
    cyc++;
    if (rst_b) begin
      sched_i.delete(); sched_q.delete(); sched_o.delete();
      exp_v = 0; exp_i = 0; exp_q = 0; exp_ovf = 0; exp_verr = 0;
    end else begin
      if (&vmask) begin
        si = 0; sq = 0; ov = 0;
        for (int k = 0; k < NCH; k++) begin
          si += ch_i[k];
          sq += ch_q[k];
        end
        s  = (sh > SUM_W - 1) ? SUM_W - 1 : sh;
        oi = fit(rnd(si, s), ov);
        oq = fit(rnd(sq, s), ov);
        sched_i[cyc + LAT - 1] = oi;
        sched_q[cyc + LAT - 1] = oq;
        sched_o[cyc + LAT - 1] = ov;
      end
      exp_v = sched_i.exists(cyc);
      if (exp_v) begin
        exp_i = sched_i[cyc];
        exp_q = sched_q[cyc];
      end
      if (exp_v && sched_o[cyc]) exp_ovf = 1;
      else if (clr)              exp_ovf = 0;
      if ((|vmask) && !(&vmask)) exp_verr = 1;
      else if (clr)              exp_verr = 0;
      if (exp_v) begin
        sched_i.delete(cyc); sched_q.delete(cyc); sched_o.delete(cyc);
      end
    end
    #1;
    chk("valid",   longint'(beam_out_valid), longint'(exp_v));
    chk("out_i",   longint'($signed(beam_outI)), exp_i);
    chk("out_q",   longint'($signed(beam_outQ)), exp_q);
    chk("ovf",     longint'(ovf_flag), longint'(exp_ovf));
    chk("vld_err", longint'(vld_err_flag), longint'(exp_verr));
  endtask

  task automatic cycle();
    apply();
    tick();
    clr = 0;
  endtask

  task automatic idle(input int n);
    vmask = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_i[k] = 0;
      ch_q[k] = 0;
    end
    repeat (n) cycle();
  endtask

  task automatic set_all(input longint vi, input longint vq);
    for (int k = 0; k < NCH; k++) begin
      ch_i[k] = vi;
      ch_q[k] = vq;
    end
  endtask

  int c0;
  int nvalid;
  logic signed [32:0] t33;

  initial begin
    rst_b = 1; clr = 0; sh = 0; vmask = '0;
    set_all(0, 0);
    apply();
    repeat (2) tick();
    chk("rst_valid", longint'(beam_out_valid), 0);
    chk("rst_out_i", longint'(beam_outI), 0);
    rst_b = 0;
    idle(2);

    // Uniform channels: 8 x 1000 and 8 x -1000
    set_all(1000, -1000); vmask = '1; sh = 0;
    cycle();
    idle(5);
    chk("t1_valid", longint'(beam_out_valid), 1);
    chk("t1_i", longint'($signed(beam_outI)), 8000);
    chk("t1_q", longint'($signed(beam_outQ)), -8000);
    idle(1);
    chk("t1_pulse", longint'(beam_out_valid), 0);

    // Half rounds toward +inf
    set_all(0, 0); vmask = '1; sh = 1; ch_i[0] = 3;
    cycle();
    ch_i[0] = -3;
    cycle();
    idle(4);
    chk("t2_first", longint'($signed(beam_outI)), 2);
    idle(1);
    chk("t2_second", longint'($signed(beam_outI)), -1);
    chk("t2_ovf", longint'(ovf_flag), 0);

    // Overflow: sum 2^23
    set_all(longint'(1) <<< 20, 0); vmask = '1; sh = 0;
    cycle();
    idle(5);
`ifdef DBF_BEAM_SUM_SAT_EN
    chk("t3_sat", longint'($signed(beam_outI)), 32767);
`else
    chk("t3_wrap", longint'($signed(beam_outI)), 0);
`endif
    chk("t3_ovf", longint'(ovf_flag), 1);
    idle(3);
    clr = 1;
    idle(1);
    chk("t3_clear", longint'(ovf_flag), 0);

    // Misaligned valid
    set_all(5, 5); vmask = 8'b0111_1111; sh = 0;
    cycle();
    idle(8);
    chk("t4_err", longint'(vld_err_flag), 1);
    clr = 1;
    idle(1);
    chk("t4_clear", longint'(vld_err_flag), 0);

    // Continuous stream with a mid-stream shift change
    c0 = cyc + 1;
    nvalid = 0;
    for (int n = 0; n < 100; n++) begin
      vmask = '1;
      sh = (n < 50) ? 0 : 2;
      for (int k = 0; k < NCH; k++) begin
        ch_i[k] = k + n;
        ch_q[k] = longint'($urandom_range(2000, 0)) - 1000;
      end
      cycle();
      nvalid += int'(beam_out_valid);
      if (cyc == c0 + 49 + LAT - 1) chk("s49", longint'($signed(beam_outI)), 420);
      if (cyc == c0 + 50 + LAT - 1) chk("s50", longint'($signed(beam_outI)), 107);
    end
    for (int j = 0; j < 8; j++) begin
      idle(1);
      nvalid += int'(beam_out_valid);
    end
    chk("stream_count", nvalid, 100);

    // Reset with three samples in flight
    vmask = '1; sh = 0;
    for (int j = 0; j < 3; j++) begin
      set_all(100 + j, -7);
      cycle();
    end
    rst_b = 1;
    idle(1);
    chk("r_out_i", longint'(beam_outI), 0);
    chk("r_valid", longint'(beam_out_valid), 0);
    rst_b = 0;
    nvalid = 0;
    for (int j = 0; j < 10; j++) begin
      idle(1);
      nvalid += int'(beam_out_valid);
    end
    chk("r_flushed", nvalid, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      vmask = ($urandom_range(9, 0) == 0) ? NCH'($urandom()) : '1;
      sh    = $urandom_range(31, 0);
      clr   = ($urandom_range(15, 0) == 0);
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(1, 0) == 1) begin
          t33 = 33'({$urandom(), $urandom()});
          ch_i[k] = longint'(t33);
          t33 = 33'({$urandom(), $urandom()});
          ch_q[k] = longint'(t33);
        end else begin
          ch_i[k] = longint'($urandom_range(8000, 0)) - 4000;
          ch_q[k] = longint'($urandom_range(8000, 0)) - 4000;
        end
      end
      if ($urandom_range(3, 0) == 0) sh = $urandom_range(2, 0);
      cycle();
    end
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
